// File: rtl/register_file_nr_1w_be_clr.sv
// Latch register file: one staged byte-enable write port, N registered
// read ports with write bypass, and a post-reset zero-fill sequencer.

module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  always_latch begin
    if (!clk_i) en_latch <= en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

module register_file_nr_1w_be_clr #(
  parameter int NUM_WORDS      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BYTE       = DATA_WIDTH / 8,
  parameter int N_READ         = 2,
  parameter int CLEAR_ON_RESET = 1,
  parameter int ADDR_WIDTH     = $clog2(NUM_WORDS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  busy_o,
  input  logic [N_READ-1:0]                     ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]     ReadData,
  input  logic                                  WriteEnable,
  input  logic [ADDR_WIDTH-1:0]                 WriteAddr,
  input  logic [NUM_BYTE-1:0][7:0]              WriteData,
  input  logic [NUM_BYTE-1:0]                   WriteBE
);

  typedef enum logic {CLR, READY} state_e;

  localparam logic [ADDR_WIDTH:0] NW =
    (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_WORDS - 1);

  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                      we_d, gate_en;
  logic [ADDR_WIDTH-1:0]     addr_d, addr_q;
  logic [NUM_BYTE-1:0]       be_d, be_q;
  logic [NUM_BYTE-1:0][7:0]  data_d, data_q;
  logic                      valid_q;

  logic [N_READ-1:0][ADDR_WIDTH-1:0] raddr_q;
  logic [NUM_WORDS-1:0][NUM_BYTE-1:0] cell_en;
  logic [7:0] mem [NUM_WORDS][NUM_BYTE];
  logic gclk;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = WriteAddr;
    be_d    = WriteBE;
    data_d  = WriteData;
    if (state_q == CLR) begin
      we_d   = 1'b1;
      addr_d = cnt_q;
      be_d   = '1;
      data_d = '0;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = READY;
    end else begin
      we_d = WriteEnable & ({1'b0, WriteAddr} < NW);
    end
  end

  assign busy_o  = (state_q == CLR);
  assign gate_en = we_d & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLR : READY;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= we_d;
      for (int p = 0; p < N_READ; p++)
        if (ReadEnable[p]) raddr_q[p] <= ReadAddr[p];
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) begin
      addr_q <= addr_d;
      be_q   <= be_d;
      data_q <= data_d;
    end
  end

  // Gate enables are decoded ahead of the edge so the latches open on
  // the high phase right after the staging registers load.
  always_comb begin
    cell_en = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      for (int b = 0; b < NUM_BYTE; b++)
        cell_en[w][b] = (addr_d == ADDR_WIDTH'(w)) & be_d[b];
  end

  cluster_clock_gating u_cg_global (
    .clk_i     (clk),
    .en_i      (gate_en),
    .test_en_i (1'b0),
    .clk_o     (gclk)
  );

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    for (genvar b = 0; b < NUM_BYTE; b++) begin : g_byte
      logic       bclk;
      logic [7:0] q;

      cluster_clock_gating u_cg (
        .clk_i     (gclk),
        .en_i      (cell_en[w][b]),
        .test_en_i (1'b0),
        .clk_o     (bclk)
      );

      always_latch begin
        if (bclk) q <= data_q[b];
      end

      assign mem[w][b] = q;
    end
  end

  always_comb begin
    ReadData = '0;
    for (int p = 0; p < N_READ; p++) begin
      for (int b = 0; b < NUM_BYTE; b++) begin
        if (!busy_o && ({1'b0, raddr_q[p]} < NW)) begin
          if (valid_q && raddr_q[p] == addr_q && be_q[b])
            ReadData[p][8*b +: 8] = data_q[b];
          else
            ReadData[p][8*b +: 8] = mem[raddr_q[p]][b];
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_nr_1w_be_clr.sv
// Random and directed bench for register_file_nr_1w_be_clr against an
// array model of word contents, read pointers and clear countdown.

module tb_register_file_nr_1w_be_clr;

  localparam int NW = 12;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int NR = 2;
  localparam int AW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   busy_o;
  logic [NR-1:0]          ReadEnable;
  logic [NR-1:0][AW-1:0]  ReadAddr;
  logic [NR-1:0][DW-1:0]  ReadData;
  logic                   WriteEnable;
  logic [AW-1:0]          WriteAddr;
  logic [NB-1:0][7:0]     WriteData;
  logic [NB-1:0]          WriteBE;

  always #5 clk = ~clk;

  register_file_nr_1w_be_clr #(
    .NUM_WORDS      (NW),
    .DATA_WIDTH     (DW),
    .N_READ         (NR),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .busy_o      (busy_o),
    .ReadEnable  (ReadEnable),
    .ReadAddr    (ReadAddr),
    .ReadData    (ReadData),
    .WriteEnable (WriteEnable),
    .WriteAddr   (WriteAddr),
    .WriteData   (WriteData),
    .WriteBE     (WriteBE)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A write accepted at an edge is visible on the next cycle;
  // the clear phase drops writes and reads as zero.
  logic [31:0]   m_mem [NW];
  logic [AW-1:0] m_ra  [NR];
  int            m_remain = 0;
  bit            m_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NW; w++) m_mem[w] = '0;
      for (int p = 0; p < NR; p++) m_ra[p] = '0;
      m_remain = NW;
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_remain > 0)
        m_remain--;
      else if (WriteEnable && int'(WriteAddr) < NW)
        for (int b = 0; b < NB; b++)
          if (WriteBE[b])
            m_mem[WriteAddr][8*b +: 8] = WriteData[b];
      for (int p = 0; p < NR; p++)
        if (ReadEnable[p]) m_ra[p] = ReadAddr[p];
    end
  end

  function automatic logic [31:0] exp_rd(int p);
    if (m_remain > 0 || int'(m_ra[p]) >= NW) return '0;
    return m_mem[m_ra[p]];
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", {31'b0, busy_o}, {31'b0, m_remain > 0});
      for (int p = 0; p < NR; p++)
        check($sformatf("rdata%0d", p), ReadData[p], exp_rd(p));
    end
  end

  task automatic wait_clear(string name);
    int n = 0;
    while (busy_o && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, n, NW);
  endtask

  task automatic rd(int p, int a);
    ReadEnable[p] = 1'b1;
    ReadAddr[p]   = AW'(a);
    @(negedge clk);
    ReadEnable[p] = 1'b0;
  endtask

  task automatic wr(int a, logic [31:0] d, logic [3:0] be);
    WriteEnable = 1'b1;
    WriteAddr   = AW'(a);
    WriteData   = d;
    WriteBE     = be;
    @(negedge clk);
    WriteEnable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ReadEnable = '0;
    ReadAddr = '0;
    WriteEnable = 1'b0;
    WriteAddr = '0;
    WriteData = '0;
    WriteBE = '0;
    repeat (3) @(negedge clk);

    // write held high through the clear must be dropped
    WriteEnable = 1'b1;
    WriteAddr = '0;
    WriteData = 32'hFFFF_FFFF;
    WriteBE = '1;
    rst = 1'b0;
    wait_clear("busy_len");
    WriteEnable = 1'b0;
    rd(0, 0);
    check("drop_busy", ReadData[0], 32'h0);

    for (int w = 0; w < NW; w++) wr(w, $urandom, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("busy_garbage");
    for (int w = 0; w < NW; w++) begin
      ReadEnable = 2'b11;
      ReadAddr[0] = AW'(w);
      ReadAddr[1] = AW'(NW - 1 - w);
      @(negedge clk);
      check("clr_p0", ReadData[0], 32'h0);
      check("clr_p1", ReadData[1], 32'h0);
    end
    ReadEnable = '0;
    rd(0, 13);
    check("oor_read", ReadData[0], 32'h0);

    wr(5, 32'hAABB_CCDD, 4'b1111);
    wr(5, 32'h1122_3344, 4'b0101);
    rd(0, 5);
    check("be_merge", ReadData[0], 32'hAA22_CC44);

    wr(4, 32'h1234_5678, 4'hF);
    WriteEnable = 1'b1;
    WriteAddr = 4'd3;
    WriteData = 32'hDEAD_BEEF;
    WriteBE = 4'b0011;
    ReadEnable = 2'b11;
    ReadAddr[0] = 4'd3;
    ReadAddr[1] = 4'd4;
    @(negedge clk);
    WriteEnable = 1'b0;
    ReadEnable = '0;
    check("bypass_p0", ReadData[0], 32'h0000_BEEF);
    check("bypass_p1", ReadData[1], 32'h1234_5678);

    rd(1, 6);
    for (int k = 1; k <= 5; k++) begin
      WriteEnable = 1'b1;
      WriteAddr = 4'd6;
      WriteData = k * 32'h0101_0101;
      WriteBE = 4'hF;
      ReadAddr[1] = AW'($urandom);
      @(negedge clk);
      check("hold_p1", ReadData[1], k * 32'h0101_0101);
    end
    WriteEnable = 1'b0;

    wr(14, 32'hFFFF_FFFF, 4'hF);
    for (int w = 0; w < NW; w++) rd(0, w);
    rd(0, 5);
    check("oor_write", ReadData[0], 32'hAA22_CC44);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid", {31'b0, busy_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("busy_abort");
    rd(1, 5);
    check("abort_clr", ReadData[1], 32'h0);

    repeat (400) begin
      rst = ($urandom_range(0, 199) == 0);
      WriteEnable = $urandom_range(0, 1) == 1;
      WriteAddr = AW'($urandom_range(0, 15));
      WriteData = $urandom;
      WriteBE = NB'($urandom);
      ReadEnable = NR'($urandom);
      ReadAddr[0] = AW'($urandom_range(0, 15));
      ReadAddr[1] = AW'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst = 1'b0;
    WriteEnable = 1'b0;
    ReadEnable = '0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/register_file_nr_1w_be_clr.md
# register_file_nr_1w_be_clr

Latch-based register file with byte-enable write, a parametrised word count that need not be a power of two, and N_READ independent registered read ports. It adds a write-to-read bypass so a word written in one cycle reads back correctly the next cycle, and an optional post-reset clear sequencer, since latches have no reset. It sits in the cluster as a drop-in, low-power storage macro for register files and small buffers fed by one producer and read by several consumers.

## Interface
- NUM_WORDS, 32: number of words; any value >= 2.
- DATA_WIDTH, 32: word width; multiple of 8.
- NUM_BYTE, DATA_WIDTH/8: byte lanes.
- N_READ, 2: number of read ports; >= 1.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = no clear, contents undefined.
- ADDR_WIDTH, $clog2(NUM_WORDS): derived; not overridden.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- busy_o  out  1  high while the clear sequence runs; writes ignored, read data forced to 0.
- ReadEnable  in  [N_READ]  per-port address capture enable.
- ReadAddr  in  [N_READ][ADDR_WIDTH]  per-port read address.
- ReadData  out  [N_READ][DATA_WIDTH]  per-port read data, from registered address.
- WriteEnable  in  1  write request.
- WriteAddr  in  ADDR_WIDTH  write address.
- WriteData  in  [NUM_BYTE][8]  write data.
- WriteBE  in  NUM_BYTE  byte enables.

## Operation
- Storage: one latch per byte per word. Each latch clock comes from a cluster_clock_gating cell per word per byte. Those cells are fed by a global gate enabled by the staged write-valid. test_en_i is tied to 0.
- Write stage 1, at posedge T: if WriteEnable is high, WriteAddr < NUM_WORDS and busy_o is low, capture address, WriteBE and the enabled data bytes into staging registers, and set the staged-valid flag. Otherwise staged-valid = 0.
- Write stage 2, cycle T+1: the gated clocks of the addressed word/enabled bytes pulse on the clk high phase, and the latches take the staged bytes.
- Read: at each posedge, port p captures ReadAddr[p] into its address register when ReadEnable[p] is high; otherwise the register holds. ReadData[p] is combinational from that register.
- Out-of-range read (registered address >= NUM_WORDS): ReadData[p] = 0. Out-of-range write: dropped, no latch touched.
- Bypass: while staged-valid is high and a port's registered address equals the staged address, the port returns the staged bytes for enabled lanes and latch contents for the others. Bypass is per port and per byte.
- Clear FSM, states CLR and READY:
  - rst high -> CLR, counter = 0, staged-valid = 0, all read address registers = 0.
  - In CLR, each cycle stages an internal full-BE write of 0 to word counter, then increments the counter.
  - On the cycle staging word NUM_WORDS-1 -> READY.
  - CLEAR_ON_RESET = 0: rst -> READY directly.
- rst asserted mid-sequence or mid-write: the sequence restarts at word 0. A staged user write is discarded and its latch update does not occur.

## Timing
- Reset values: busy_o = CLEAR_ON_RESET; ReadData = 0 on all ports (forced while busy_o is high); read address registers = 0.
- busy_o stays high for exactly NUM_WORDS cycles after the first posedge with rst low. The first user write is accepted at the edge where busy_o is already low.
- Write-to-read latency: write at edge T, read address captured at edge T -> new data on ReadData during T+1 via bypass. Captured at T+1 or later -> taken from the latches.
- Read latency: one cycle from address capture. ReadData is stable for the whole cycle and changes only after posedge.
- A write and a read of the same word at the same edge is legal. Any number of ports may read the same word.
- Back-to-back writes to the same word every cycle are legal. Each byte lane resolves to the most recent enabled write.

## Test plan
- Reset clear: NUM_WORDS=12, CLEAR_ON_RESET=1, pre-load garbage, pulse rst -> busy_o high for 12 cycles; then both ports read every word = 0; address 13 reads 0.
- Byte-enable write: write 0xAABBCCDD to word 5 with BE=4'b1111, then 0x11223344 with BE=4'b0101 -> reads 0xAA22CC44.
- Bypass: port0 reads word 3 at the same edge as a write of 0xDEADBEEF, BE=4'b0011, to word 3 (old 0) -> next cycle ReadData[0] = 0x0000BEEF; port1 reading word 4 is unaffected.
- Hold: ReadEnable[1] low for 5 cycles while word under port1 is rewritten -> ReadData[1] tracks the new contents of the held address; ReadAddr changes are ignored.
- Busy/reset abort: write during busy_o -> dropped (word still 0 after clear). Assert rst at clear word 7 -> busy_o high 12 more cycles.
- Out-of-range write to address 14 with NUM_WORDS=12 -> no word changes, verified by a full readback.
